// File: rtl/cell_pos_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cell_pos_reader_if
// RAM read port and particle stream bundled for the cell position reader.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface cell_pos_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_rden;
  logic                  ram_wren;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  modport master (
    output ram_address, ram_rden, ram_wren, ram_data,
    input  ram_q,
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  ram_address, ram_rden, ram_wren, ram_data,
    output ram_q,
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/cell_pos_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cell_pos_reader
// Reads the particle count then streams particles 1..N from a cell RAM.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  start,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      particle_count,
  output logic                       count_clamped,
  cell_pos_reader_if.master          bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(FIFO_DEPTH + 4) + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CNT_REQ  = 3'd1,
    S_CNT_WAIT = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  clamped_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rden_q;

  logic                  s1_vld_q;
  logic                  s2_vld_q;
  logic [ADDR_WIDTH-1:0] s1_idx_q;
  logic [ADDR_WIDTH-1:0] s2_idx_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_idx_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q;
  logic [CNT_W-1:0]      fifo_cnt_d;

  logic                  push;
  logic                  pop;
  logic [CRD_W-1:0]      committed;
  logic                  can_issue;
  logic [ADDR_WIDTH-1:0] raw_count;
  logic                  over;
  logic [ADDR_WIDTH-1:0] clamped_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Address 0 is the count read; its return is consumed by the FSM, not the FIFO.
  assign push = s2_vld_q && (s2_idx_q != '0);
  assign pop  = (fifo_cnt_q != '0) && bus.out_ready;

  // Every read already issued will land in the FIFO, so it is charged as occupied.
  assign committed = CRD_W'(fifo_cnt_q) + CRD_W'(rden_q) + CRD_W'(s1_vld_q)
                   + CRD_W'(s2_vld_q) - CRD_W'(pop);
  assign can_issue = committed < CRD_W'(FIFO_DEPTH);

  assign raw_count     = bus.ram_q[ADDR_WIDTH-1:0];
  assign over          = raw_count > MAX_COUNT;
  assign clamped_count = over ? MAX_COUNT : raw_count;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_idx_q <= '0;
      s2_idx_q <= '0;
    end else begin
      s1_vld_q <= rden_q;
      s1_idx_q <= addr_q;
      s2_vld_q <= s1_vld_q;
      s2_idx_q <= s1_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.ram_q;
        fifo_idx_q[wr_ptr_q]  <= s2_idx_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      count_q   <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      rden_q    <= 1'b0;
    end else begin
      rden_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_CNT_REQ;
            busy_q    <= 1'b1;
            clamped_q <= 1'b0;
            addr_q    <= '0;
            rden_q    <= 1'b1;
          end
        end
        S_CNT_REQ: begin
          state_q <= S_CNT_WAIT;
        end
        S_CNT_WAIT: begin
          if (s2_vld_q) begin
            count_q   <= clamped_count;
            clamped_q <= over;
            if (clamped_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= (clamped_count == ADDR_WIDTH'(1)) ? S_DRAIN : S_STREAM;
              rden_q  <= 1'b1;
              addr_q  <= ADDR_WIDTH'(1);
              ptr_q   <= ADDR_WIDTH'(2);
            end
          end
        end
        S_STREAM: begin
          if (can_issue) begin
            rden_q <= 1'b1;
            addr_q <= ptr_q;
            ptr_q  <= ptr_q + ADDR_WIDTH'(1);
            if (ptr_q == count_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Finish on the cycle the last word leaves so done follows the final transfer.
          if ((fifo_cnt_d == '0) && !rden_q && !s1_vld_q && !s2_vld_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign particle_count = count_q;
  assign count_clamped  = clamped_q;

  assign bus.ram_address = addr_q;
  assign bus.ram_rden    = rden_q;
  assign bus.ram_wren    = 1'b0;
  assign bus.ram_data    = '0;

  assign bus.out_valid = (fifo_cnt_q != '0);
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_index = fifo_idx_q[rd_ptr_q];
  assign bus.out_last  = bus.out_valid && (fifo_idx_q[rd_ptr_q] == count_q);

endmodule
`default_nettype wire

// File: tb/tb_cell_pos_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cell_pos_reader
// Scoreboard bench for cell_pos_reader: RAM model, random backpressure, timing.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cell_pos_reader;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int FD = 4;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start2;
  logic          busy, done, clamped, busy2, done2, clamped2;
  logic [AW-1:0] pcount, pcount2;

  cell_pos_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  cell_pos_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  cell_pos_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(pcount), .count_clamped(clamped), .bus(bus)
  );

  cell_pos_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .particle_count(pcount2), .count_clamped(clamped2), .bus(bus2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int t2    = 0;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] st1 = '0, st2 = '0, st1b = '0, st2b = '0;

  exp_t sb[$];
  exp_t sb2[$];
  exp_t e, e2;
  int   rd_cyc[$];
  int   rd_addr[$];
  int   xfer_cyc[$];
  int   done_cnt = 0, done_rel = -1;
  int   done2_cnt = 0, done2_rel = -1, xfer2 = 0;
  int   outstanding = 0;
  bit   chk_credit = 1'b0;
  bit   rand_ready = 1'b0;
  logic ready_fix = 1'b1;

  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_i;
  logic          hold_l;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i, input int seed);
    return {32'(seed * 1000 + i), 32'(i * 7 + seed), 32'hF00D0000 ^ 32'(i)};
  endfunction

  // Loads the RAM image and queues the expected particle stream for one DUT.
  task automatic prep(input int raw, input int seed, input int which);
    int n;
    n = (raw > PN - 1) ? PN - 1 : raw;
    mem[0] = DW'(raw);
    for (int i = 1; i < 256; i++) mem[i] = word(i, seed);
    rd_cyc.delete(); rd_addr.delete(); xfer_cyc.delete();
    done_rel = -1; done_cnt = 0; outstanding = 0;
    for (int i = 1; i <= n; i++) begin
      if (which == 2) sb2.push_back('{idx: AW'(i), data: word(i, seed), last: (i == n)});
      else            sb.push_back('{idx: AW'(i), data: word(i, seed), last: (i == n)});
    end
  endtask

  task automatic kick();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin @(posedge clk); k++; end
    #1;
    check("done_seen", done_cnt != 0, 1);
  endtask

  // RAM models: data for a read enabled in cycle k is presented during cycle k+2.
  initial forever begin
    @(negedge clk);
    bus.ram_q  = st2;
    st2        = st1;
    st1        = bus.ram_rden ? mem[bus.ram_address] : '0;
    bus2.ram_q = st2b;
    st2b       = st1b;
    st1b       = bus2.ram_rden ? mem[bus2.ram_address] : '0;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_v = 1'b0;
      outstanding = 0;
    end else begin
      if (bus.ram_rden) begin
        rd_cyc.push_back(cyc - t0);
        rd_addr.push_back(int'(bus.ram_address));
        if (bus.ram_address != '0) outstanding++;
      end
      if (chk_credit) check("credit_bound", outstanding <= FD, 1);
      if (done) begin done_cnt++; done_rel = cyc - t0; end
      if (hold_v) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, hold_d);
        check("hold_index", bus.out_index, hold_i);
        check("hold_last", bus.out_last, hold_l);
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cyc.push_back(cyc - t0);
        outstanding--;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_xfer: got index %0d expected none", bus.out_index);
        end else begin
          e = sb.pop_front();
          check("out_index", bus.out_index, e.idx);
          check("out_data", bus.out_data, e.data);
          check("out_last", bus.out_last, e.last);
        end
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_i = bus.out_index;
      hold_l = bus.out_last;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (done2) begin done2_cnt++; done2_rel = cyc - t2; end
      if (bus2.out_valid && bus2.out_ready) begin
        xfer2++;
        if (sb2.size() == 0) begin
          total++; bad++;
          $display("FAIL d2_unexpected_xfer: got index %0d expected none", bus2.out_index);
        end else begin
          e2 = sb2.pop_front();
          check("d2_index", bus2.out_index, e2.idx);
          check("d2_data", bus2.out_data, e2.data);
          check("d2_last", bus2.out_last, e2.last);
        end
      end
    end
  end

  initial begin
    int exp_rc[4];
    int exp_xc[3];
    int zeros;
    bit seen_v;
    int k;
    exp_rc = '{1, 4, 5, 6};
    exp_xc = '{7, 8, 9};
    rst = 1'b1; start = 1'b0; start2 = 1'b0; bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pcount", pcount, 0);
    check("rst_clamped", clamped, 0);
    check("rst_addr", bus.ram_address, 0);
    check("rst_rden", bus.ram_rden, 0);
    check("rst_wren", bus.ram_wren, 0);
    check("rst_ram_data", bus.ram_data, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);

    // Three particles, full-rate consumer: exact cycle timing.
    prep(3, 1, 1);
    kick();
    wait_done(100);
    repeat (2) @(posedge clk);
    #1;
    check("t1_rd_count", rd_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_rd_cyc", (i < rd_cyc.size()) ? rd_cyc[i] : -1, exp_rc[i]);
      check("t1_rd_addr", (i < rd_addr.size()) ? rd_addr[i] : -1, i);
    end
    check("t1_xfer_count", xfer_cyc.size(), 3);
    for (int i = 0; i < 3; i++)
      check("t1_xfer_cyc", (i < xfer_cyc.size()) ? xfer_cyc[i] : -1, exp_xc[i]);
    check("t1_done_cyc", done_rel, 10);
    check("t1_pcount", pcount, 3);
    check("t1_clamped", clamped, 0);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_busy_after", busy, 0);

    // Empty cell.
    prep(0, 2, 1);
    kick();
    wait_done(100);
    repeat (2) @(posedge clk);
    #1;
    check("t2_done_cyc", done_rel, 4);
    check("t2_rd_count", rd_cyc.size(), 1);
    check("t2_xfer_count", xfer_cyc.size(), 0);
    check("t2_pcount", pcount, 0);

    // Random backpressure with the credit bound watched every cycle.
    prep(10, 3, 1);
    rand_ready = 1'b1;
    chk_credit = 1'b1;
    kick();
    wait_done(600);
    chk_credit = 1'b0;
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_xfer_count", xfer_cyc.size(), 10);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_pcount", pcount, 10);

    // Oversized count is clamped to PARTICLE_NUM-1.
    prep(250, 4, 1);
    kick();
    wait_done(3000);
    repeat (2) @(posedge clk);
    #1;
    check("t4_pcount", pcount, PN - 1);
    check("t4_clamped", clamped, 1);
    check("t4_xfer_count", xfer_cyc.size(), PN - 1);
    check("t4_sb_empty", sb.size(), 0);

    // Reset in cycle 6 while reads are still returning.
    prep(10, 5, 1);
    kick();
    repeat (5) @(posedge clk);
    #1;
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_pcount", pcount, 0);
    check("t5_clamped", clamped, 0);
    check("t5_addr", bus.ram_address, 0);
    check("t5_rden", bus.ram_rden, 0);
    check("t5_valid", bus.out_valid, 0);
    check("t5_last", bus.out_last, 0);
    sb.delete();
    seen_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_v = 1'b1;
    end
    check("t5_no_stale", seen_v, 0);
    prep(5, 6, 1);
    kick();
    wait_done(100);
    repeat (2) @(posedge clk);
    #1;
    check("t5_new_pcount", pcount, 5);
    check("t5_new_xfer", xfer_cyc.size(), 5);
    check("t5_new_sb_empty", sb.size(), 0);

    // start during STREAM (cycle 5) and in the DONE cycle (cycle 11) is ignored.
    prep(4, 7, 1);
    kick();
    repeat (4) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    zeros = 0;
    foreach (rd_addr[i]) if (rd_addr[i] == 0) zeros++;
    check("t6_done_count", done_cnt, 1);
    check("t6_done_cyc", done_rel, 11);
    check("t6_count_reads", zeros, 1);
    check("t6_xfer_count", xfer_cyc.size(), 4);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_busy_idle", busy, 0);

    // Two-entry FIFO variant still completes the run.
    prep(6, 8, 2);
    @(posedge clk); #1;
    start2 = 1'b1;
    t2 = cyc;
    @(posedge clk); #1;
    start2 = 1'b0;
    k = 0;
    while (done2_cnt == 0 && k < 300) begin @(posedge clk); k++; end
    #1;
    check("d2_done_seen", done2_cnt, 1);
    check("d2_xfer_count", xfer2, 6);
    check("d2_sb_empty", sb2.size(), 0);
    check("d2_pcount", pcount2, 6);
    check("d2_rate", done2_rel >= 12, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
